// File: rtl/instruction_issue.sv
// instruction_issue: fetches instruction words from RAM starting at base_addr,
// issues them to the decoder one at a time and stalls on fetch/compute
// handshakes. Opcode 0x82 ends the program.
// Optional feature: define INSTR_HOLD_EN to add the resume port and HOLD state
// (opcode 0x44 parks the issuer until resume).
module instruction_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] base_addr,
   output logic        instr_rd_en,
   output logic [15:0] instr_rd_addr,
   input  logic [63:0] instr_rd_data,
   output logic [63:0] instruction,
   output logic        instr_enable,
   input  logic        fetch_done,
   input  logic        compute_done,
   output logic        busy,
   output logic        prog_done,
   output logic [15:0] issue_count
`ifdef INSTR_HOLD_EN
   ,
   input  logic        resume
`endif
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ      = 3'd1,
      WAIT_DATA = 3'd2,
      ISSUE     = 3'd3,
      WAIT_ACK  = 3'd4,
      DONE      = 3'd5
`ifdef INSTR_HOLD_EN
      ,
      HOLD      = 3'd6
`endif
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc, pc_next;
   logic [63:0] capture, word_next;
   logic        ack_compute, ack_compute_next;
   logic [15:0] count_next;

   // Next-state, program counter, capture and issue-count logic
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      word_next        = capture;
      ack_compute_next = ack_compute;
      count_next       = issue_count;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               pc_next    = base_addr;
               count_next = '0;
               state_next = READ;
            end
         end
         READ: state_next = WAIT_DATA;
         WAIT_DATA: begin
            word_next  = instr_rd_data;
            state_next = ISSUE;
         end
         ISSUE: begin
            pc_next = pc + 16'd1;
            if (issue_count != 16'hFFFF) count_next = issue_count + 16'd1;
            case (capture[63:56])
               8'h01, 8'h02, 8'h04: begin
                  ack_compute_next = 1'b0;
                  state_next       = WAIT_ACK;
               end
               8'h81: begin
                  ack_compute_next = 1'b1;
                  state_next       = WAIT_ACK;
               end
               8'h82: state_next = DONE;
`ifdef INSTR_HOLD_EN
               8'h44: state_next = HOLD;
`endif
               default: state_next = READ;
            endcase
         end
         WAIT_ACK: begin
            if (ack_compute ? compute_done : fetch_done) state_next = READ;
         end
`ifdef INSTR_HOLD_EN
         HOLD: begin
            if (resume) state_next = READ;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Datapath and outputs, registered from the next state so each output
   // is valid during the state it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc            <= '0;
         capture       <= '0;
         ack_compute   <= 1'b0;
         issue_count   <= '0;
         instr_rd_en   <= 1'b0;
         instr_rd_addr <= '0;
         instr_enable  <= 1'b0;
         instruction   <= '0;
         busy          <= 1'b0;
         prog_done     <= 1'b0;
      end else begin
         pc           <= pc_next;
         capture      <= word_next;
         ack_compute  <= ack_compute_next;
         issue_count  <= count_next;
         instr_rd_en  <= (state_next == READ);
         instr_enable <= (state_next == ISSUE);
         busy         <= !((state_next == IDLE) || (state_next == DONE));
         prog_done    <= (state_next == DONE);
         if (state_next == READ)  instr_rd_addr <= pc_next;
         if (state_next == ISSUE) instruction   <= word_next;
      end
   end

endmodule

// File: tb/tb_instruction_issue.sv
// Directed testbench for instruction_issue with a behavioural one-cycle RAM.
module tb_instruction_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_addr;
   logic        instr_rd_en;
   logic [15:0] instr_rd_addr;
   logic [63:0] instr_rd_data = '0;
   logic [63:0] instruction;
   logic        instr_enable;
   logic        fetch_done;
   logic        compute_done;
   logic        busy;
   logic        prog_done;
   logic [15:0] issue_count;
`ifdef INSTR_HOLD_EN
   logic        resume;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int reads;
   int pulses;
   int first;
   int overlap;

   logic [63:0] mem [logic [15:0]];

   instruction_issue dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .instr_rd_en   (instr_rd_en),
      .instr_rd_addr (instr_rd_addr),
      .instr_rd_data (instr_rd_data),
      .instruction   (instruction),
      .instr_enable  (instr_enable),
      .fetch_done    (fetch_done),
      .compute_done  (compute_done),
      .busy          (busy),
      .prog_done     (prog_done),
      .issue_count   (issue_count)
`ifdef INSTR_HOLD_EN
      ,
      .resume        (resume)
`endif
   );

   always #5 clk = ~clk;

   // Instruction RAM: data valid one cycle after the read strobe
   always @(posedge clk) begin
      if (instr_rd_en)
         instr_rd_data <= mem.exists(instr_rd_addr) ? mem[instr_rd_addr] : 64'h0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_en"},   instr_rd_en,   0);
      chk({tag, "_rd_addr"}, instr_rd_addr, 0);
      chk({tag, "_instr"},   instruction,   0);
      chk({tag, "_en"},      instr_enable,  0);
      chk({tag, "_busy"},    busy,          0);
      chk({tag, "_done"},    prog_done,     0);
      chk({tag, "_count"},   issue_count,   0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0;
      fetch_done = 1'b0; compute_done = 1'b0;
`ifdef INSTR_HOLD_EN
      resume = 1'b0;
`endif
      mem[16'h0010] = 64'h4003_0000_0000_1010;
      mem[16'h0011] = 64'h8200_0000_0000_1011;
      mem[16'h0020] = 64'h0405_0000_0000_2020;
      mem[16'h0021] = 64'h8201_0000_0000_2021;
      mem[16'h0030] = 64'h8107_0000_0000_3030;
      mem[16'h0031] = 64'h0102_0000_0000_3031;
      mem[16'h0032] = 64'h8200_0000_0000_3032;
      mem[16'hFFFF] = 64'h4000_0000_0000_FFFF;
      mem[16'h0000] = 64'h8209_0000_0000_0F00;
      mem[16'h0050] = 64'h4402_0000_0000_5050;
      mem[16'h0051] = 64'h8200_0000_0000_5051;
      mem[16'h0077] = 64'h4000_0000_0000_7777;

      // Reset state
      tick(); tick();
      chk_zero("rst_init");
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Program {0x40, 0x82} at 0x0010
      base_addr = 16'h0010; start = 1'b1; tick(); start = 1'b0;
      chk("p1_rd_en", instr_rd_en, 1);
      chk("p1_rd_addr", instr_rd_addr, 16'h0010);
      chk("p1_busy", busy, 1);
      pulses = 0; first = 0; overlap = 0;
      for (int c = 1; c <= 12; c++) begin
         if (instr_enable) begin
            pulses++;
            if (pulses == 1) first = c;
         end
         if (instr_enable && instr_rd_en) overlap = 1;
         tick();
      end
      chk("p1_pulses", pulses, 2);
      chk("p1_first", first, 3);
      chk("p1_overlap", overlap, 0);
      chk("p1_done", prog_done, 1);
      chk("p1_count", issue_count, 2);
      chk("p1_busy_end", busy, 0);
      chk("p1_instr_hold", instruction, 64'h8200_0000_0000_1011);

      // Program {0x04, 0x82}: long fetch wait, stray compute_done and start
      base_addr = 16'h0020; start = 1'b1; tick(); start = 1'b0; base_addr = 16'h0077;
      chk("p2_done_clr", prog_done, 0);
      chk("p2_count_clr", issue_count, 0);
      tick(); tick();
      chk("p2_en", instr_enable, 1);
      chk("p2_instr", instruction, 64'h0405_0000_0000_2020);
      tick();
      reads = 0;
      for (int c = 0; c < 20; c++) begin
         if (instr_rd_en) reads++;
         compute_done = (c == 5);
         start = (c == 8);
         tick();
      end
      compute_done = 1'b0; start = 1'b0;
      chk("p2_no_read", reads, 0);
      chk("p2_busy_wait", busy, 1);
      fetch_done = 1'b1; tick(); fetch_done = 1'b0;
      chk("p2_resume_rd", instr_rd_en, 1);
      chk("p2_resume_addr", instr_rd_addr, 16'h0021);
      tick(); tick();
      chk("p2_instr2", instruction, 64'h8201_0000_0000_2021);
      tick();
      chk("p2_done", prog_done, 1);
      chk("p2_count", issue_count, 2);

      // Program {0x81, 0x01, 0x82}: wrong-source and stale done pulses
      base_addr = 16'h0030; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("p3_instr", instruction, 64'h8107_0000_0000_3030);
      tick();
      fetch_done = 1'b1; tick(); fetch_done = 1'b0;
      reads = 0;
      for (int c = 0; c < 4; c++) begin
         if (instr_rd_en) reads++;
         tick();
      end
      chk("p3_fetch_ignored", reads, 0);
      compute_done = 1'b1; tick(); compute_done = 1'b0;
      chk("p3_resume_rd", instr_rd_en, 1);
      chk("p3_resume_addr", instr_rd_addr, 16'h0031);
      tick(); tick();
      chk("p3_instr2", instruction, 64'h0102_0000_0000_3031);
      fetch_done = 1'b1; tick(); fetch_done = 1'b0;
      reads = 0;
      for (int c = 0; c < 4; c++) begin
         if (instr_rd_en) reads++;
         tick();
      end
      chk("p3_stale_fetch", reads, 0);
      fetch_done = 1'b1; tick(); fetch_done = 1'b0;
      chk("p3_rd3_addr", instr_rd_addr, 16'h0032);
      tick(); tick(); tick();
      chk("p3_done", prog_done, 1);
      chk("p3_count", issue_count, 3);

      // Address wrap from 0xFFFF
      base_addr = 16'hFFFF; start = 1'b1; tick(); start = 1'b0;
      chk("p4_addr0", instr_rd_addr, 16'hFFFF);
      tick(); tick(); tick();
      chk("p4_rd_en1", instr_rd_en, 1);
      chk("p4_addr1", instr_rd_addr, 16'h0000);
      tick(); tick();
      chk("p4_instr", instruction, 64'h8209_0000_0000_0F00);
      tick();
      chk("p4_done", prog_done, 1);

      // Opcode 0x44
      base_addr = 16'h0050; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("p5_instr", instruction, 64'h4402_0000_0000_5050);
      tick();
`ifdef INSTR_HOLD_EN
      chk("p5_hold_busy", busy, 1);
      reads = 0;
      for (int c = 0; c < 6; c++) begin
         if (instr_rd_en || instr_enable) reads++;
         tick();
      end
      chk("p5_hold_quiet", reads, 0);
      resume = 1'b1; tick(); resume = 1'b0;
`endif
      chk("p5_next_rd", instr_rd_en, 1);
      chk("p5_next_addr", instr_rd_addr, 16'h0051);
      tick(); tick(); tick();
      chk("p5_done", prog_done, 1);
      chk("p5_count", issue_count, 2);

      // Reset during WAIT_ACK, then re-run
      base_addr = 16'h0020; start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick(); tick();
      chk("p6_waiting", busy, 1);
      rst = 1'b1; #1;
      chk_zero("rst_mid");
      tick(); rst = 1'b0;
      reads = 0;
      for (int c = 0; c < 6; c++) begin
         if (instr_enable || busy) reads++;
         tick();
      end
      chk("p6_quiet", reads, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk("p6_rd_addr", instr_rd_addr, 16'h0020);
      tick(); tick();
      chk("p6_en", instr_enable, 1);
      tick();
      chk("p6_count", issue_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
